// File: rtl/trig_hist_pkg.sv
// Shared sizing and types for the trigger-pattern histogrammer.
package trig_hist_pkg;
  localparam int PW      = 5;
  localparam int NBINS   = 1 << PW;
  localparam int CW      = 32;
  localparam int PMT_BIT = 4;

  typedef logic [NBINS-1:0][CW-1:0] hist_t;
  typedef logic [1:0][CW-1:0]       tot_t;

  typedef enum logic {V_IDLE, V_WINDOW} veto_st_e;
endpackage

// File: rtl/trig_histogrammer_sat_counter.sv
// Saturating counter with synchronous clear; clear and increment together give 1.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)                q_d = inc ? W'(1) : '0;
    else if (inc && ~&q_q)  q_d = q_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;

  assign q = q_q;
endmodule

// File: rtl/trig_histogrammer.sv
// Counts qualified trigger patterns into per-pattern bins with a PMT-last veto window.
module trig_histogrammer #(
  parameter int PW      = trig_hist_pkg::PW,
  parameter int NBINS   = trig_hist_pkg::NBINS,
  parameter int CW      = trig_hist_pkg::CW,
  parameter int PMT_BIT = trig_hist_pkg::PMT_BIT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hit_valid,
  input  logic [PW-1:0]              hit_pattern,
  input  logic [2:0]                 vetopmtlast,
  input  logic                       resethist,
  output logic [NBINS-1:0][CW-1:0]   h,
  output logic [1:0][CW-1:0]         h_out,
  output logic                       veto_active
);
  import trig_hist_pkg::veto_st_e;
  import trig_hist_pkg::V_IDLE;
  import trig_hist_pkg::V_WINDOW;

  logic          s1_valid_q, s1_valid_d;
  logic [PW-1:0] s1_pat_q, s1_pat_d;
  logic [2:0]    vcnt_q, vcnt_d;
  veto_st_e      st_q, st_d;
  logic          accepted, vetoed;
  logic [NBINS-1:0] bin_inc;

  always_comb begin
    s1_valid_d = hit_valid;
    s1_pat_d   = hit_pattern;
    accepted   = s1_valid_q && (vcnt_q == 3'd0);
    vetoed     = s1_valid_q && (vcnt_q != 3'd0);
    vcnt_d     = vcnt_q;
    // A load needs vcnt==0, so it can never collide with a decrement.
    if (vcnt_q != 3'd0)
      vcnt_d = vcnt_q - 3'd1;
    else if (accepted && s1_pat_q[PMT_BIT] && (vetopmtlast != 3'd0))
      vcnt_d = vetopmtlast;
    st_d = st_q;
    case (st_q)
      V_IDLE:   if (vcnt_d != 3'd0) st_d = V_WINDOW;
      V_WINDOW: if (vcnt_d == 3'd0) st_d = V_IDLE;
      default:  st_d = V_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_pat_q   <= '0;
      vcnt_q     <= '0;
      st_q       <= V_IDLE;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_pat_q   <= s1_pat_d;
      vcnt_q     <= vcnt_d;
      st_q       <= st_d;
    end

  assign veto_active = (st_q == V_WINDOW);

  for (genvar g = 0; g < NBINS; g++) begin : g_bin
    assign bin_inc[g] = accepted && (s1_pat_q == PW'(g));
    sat_counter #(.W(CW)) u_cnt (
      .clk(clk), .rst_n(rst_n), .clr(resethist), .inc(bin_inc[g]), .q(h[g])
    );
  end

  sat_counter #(.W(CW)) u_acc (
    .clk(clk), .rst_n(rst_n), .clr(resethist), .inc(accepted), .q(h_out[0])
  );
  sat_counter #(.W(CW)) u_vet (
    .clk(clk), .rst_n(rst_n), .clr(resethist), .inc(vetoed), .q(h_out[1])
  );
endmodule

// File: tb/tb_trig_histogrammer.sv
// Randomized and directed bench for trig_histogrammer against a cycle-indexed window model.
module tb_trig_histogrammer;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             hit_valid = 1'b0;
  logic [4:0]       hit_pattern = '0;
  logic [2:0]       vetopmtlast = '0;
  logic             resethist = 1'b0;
  logic [31:0][31:0] h;
  logic [1:0][31:0]  h_out;
  logic              veto_active;
  logic [31:0][3:0]  h_s;
  logic [1:0][3:0]   h_out_s;
  logic              veto_active_s;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  trig_histogrammer dut (
    .clk(clk), .rst_n(rst_n), .hit_valid(hit_valid), .hit_pattern(hit_pattern),
    .vetopmtlast(vetopmtlast), .resethist(resethist),
    .h(h), .h_out(h_out), .veto_active(veto_active)
  );

  // Narrow-counter copy on the same stimulus so saturation is reachable.
  trig_histogrammer #(.CW(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .hit_valid(hit_valid), .hit_pattern(hit_pattern),
    .vetopmtlast(vetopmtlast), .resethist(resethist),
    .h(h_s), .h_out(h_out_s), .veto_active(veto_active_s)
  );

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned sat(input longint unsigned x, input int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 64'd1;
    return (x > mx) ? mx : x;
  endfunction

  // Reference: unbounded counts, an event in cycle c is vetoed iff c <= veto_end.
  longint unsigned m_h[32];
  longint unsigned m_acc, m_vet;
  int              cyc, veto_end;
  logic            m_s1v;
  logic [4:0]      m_s1p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_h[i]) m_h[i] <= 0;
      m_acc <= 0; m_vet <= 0; m_s1v <= 1'b0; m_s1p <= '0;
      cyc <= 0; veto_end <= -1;
    end else begin
      if (resethist) begin
        foreach (m_h[i]) m_h[i] <= 0;
        m_acc <= 0; m_vet <= 0;
      end
      if (m_s1v) begin
        if (cyc <= veto_end) m_vet <= (resethist ? 0 : m_vet) + 1;
        else begin
          m_h[m_s1p] <= (resethist ? 0 : m_h[m_s1p]) + 1;
          m_acc      <= (resethist ? 0 : m_acc) + 1;
          if (m_s1p[4] && vetopmtlast != 0) veto_end <= cyc + int'(vetopmtlast);
        end
      end
      m_s1v <= hit_valid;
      m_s1p <= hit_pattern;
      cyc   <= cyc + 1;
    end
  end

  always @(negedge clk) if (chk_en) begin
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("h[%0d]", i), h[i], sat(m_h[i], 32));
      chk($sformatf("hs[%0d]", i), h_s[i], sat(m_h[i], 4));
    end
    chk("acc", h_out[0], sat(m_acc, 32));
    chk("vet", h_out[1], sat(m_vet, 32));
    chk("acc_s", h_out_s[0], sat(m_acc, 4));
    chk("vet_s", h_out_s[1], sat(m_vet, 4));
    chk("veto_active", veto_active, (cyc <= veto_end));
    chk("veto_active_s", veto_active_s, (cyc <= veto_end));
  end

  task automatic drive(input logic v, input logic [4:0] p, input logic rh);
    hit_valid = v; hit_pattern = p; resethist = rh;
    @(posedge clk); #1;
  endtask

  task automatic clear_all();
    drive(1'b0, 5'd0, 1'b1);
    drive(1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    int va_cnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_acc", h_out[0], 0);
    chk("rst_va", veto_active, 0);
    @(posedge clk); #1;

    // single event into bin 5
    drive(1'b1, 5'h05, 1'b0);
    drive(1'b0, 5'h00, 1'b0);
    @(negedge clk);
    chk("single_h5", h[5], 1);
    chk("single_acc", h_out[0], 1);
    chk("single_h4", h[4], 0);
    @(posedge clk); #1;

    // veto window of 3
    vetopmtlast = 3'd3;
    clear_all();
    va_cnt = 0;
    drive(1'b1, 5'h10, 1'b0); va_cnt += int'(veto_active);
    for (int k = 1; k <= 4; k++) begin drive(1'b1, 5'(k), 1'b0); va_cnt += int'(veto_active); end
    for (int k = 0; k < 5; k++)  begin drive(1'b0, 5'd0, 1'b0);  va_cnt += int'(veto_active); end
    chk("win_vet", h_out[1], 3);
    chk("win_acc", h_out[0], 2);
    chk("win_h16", h[16], 1);
    chk("win_h4", h[4], 1);
    chk("win_h2", h[2], 0);
    chk("win_va_cycles", va_cnt, 3);

    // veto disabled
    vetopmtlast = 3'd0;
    clear_all();
    va_cnt = 0;
    for (int k = 0; k < 10; k++) begin drive(1'b1, 5'h10 | 5'(k & 7), 1'b0); va_cnt += int'(veto_active); end
    drive(1'b0, 5'd0, 1'b0); drive(1'b0, 5'd0, 1'b0);
    chk("dis_acc", h_out[0], 10);
    chk("dis_vet", h_out[1], 0);
    chk("dis_va", va_cnt, 0);

    // clear coinciding with an s1 event
    clear_all();
    for (int k = 0; k < 8; k++) drive(1'b1, 5'd2, 1'b0);
    drive(1'b0, 5'd0, 1'b1);
    drive(1'b0, 5'd0, 1'b0);
    chk("clr_h2", h[2], 1);
    chk("clr_acc", h_out[0], 1);
    chk("clr_vet", h_out[1], 0);

    // saturation on the narrow instance
    clear_all();
    for (int k = 0; k < 20; k++) drive(1'b1, 5'h1F, 1'b0);
    drive(1'b0, 5'd0, 1'b0); drive(1'b0, 5'd0, 1'b0);
    chk("sat_h31_s", h_s[31], 15);
    chk("sat_acc_s", h_out_s[0], 15);
    chk("sat_h31", h[31], 20);

    // async reset mid-window with s1 valid
    vetopmtlast = 3'd4;
    clear_all();
    drive(1'b1, 5'h10, 1'b0);
    drive(1'b1, 5'h01, 1'b0);
    drive(1'b1, 5'h01, 1'b0);
    drive(1'b1, 5'h01, 1'b0);
    chk("pre_rst_va", veto_active, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_acc", h_out[0], 0);
    chk("mid_rst_vet", h_out[1], 0);
    chk("mid_rst_h16", h[16], 0);
    chk("mid_rst_va", veto_active, 0);
    hit_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 5'd7, 1'b0);
    drive(1'b0, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 1'b0);
    chk("post_rst_h7", h[7], 1);
    chk("post_rst_acc", h_out[0], 1);
    chk("post_rst_vet", h_out[1], 0);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 31) == 0) vetopmtlast = 3'($urandom_range(0, 7));
      drive(($urandom_range(0, 9) < 7),
            5'($urandom_range(0, 31)),
            ($urandom_range(0, 99) == 0));
    end
    drive(1'b0, 5'd0, 1'b0);
    drive(1'b0, 5'd0, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
